// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the SS.cc stopwatch: controller state, BCD digit
// type and the packed four-digit time value.
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t CS_DIGIT_MAX = BCD_W'(9);
  localparam bcd_t SEC10_MAX    = BCD_W'(5);

  typedef struct packed {
    bcd_t sec10;
    bcd_t sec1;
    bcd_t cs10;
    bcd_t cs1;
  } sw_time_t;

endpackage

// File: rtl/bcd_cascade_ss_cc.sv
// SS.cc BCD counter chain: cs1 -> cs10 -> sec1 -> sec10, rolling 59.99 to 00.00
// with a one-cycle registered wrap pulse.
module bcd_cascade_ss_cc
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic reset_p,
  input  logic inc,
  input  logic clr,
  output bcd_t cs1,
  output bcd_t cs10,
  output bcd_t sec1,
  output bcd_t sec10,
  output logic wrap
);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cs1   <= '0;
      cs10  <= '0;
      sec1  <= '0;
      sec10 <= '0;
      wrap  <= 1'b0;
    end else if (clr) begin
      cs1   <= '0;
      cs10  <= '0;
      sec1  <= '0;
      sec10 <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (inc) begin
        if (cs1 == CS_DIGIT_MAX) begin
          cs1 <= '0;
          if (cs10 == CS_DIGIT_MAX) begin
            cs10 <= '0;
            if (sec1 == CS_DIGIT_MAX) begin
              sec1 <= '0;
              // Top digit saturating at 5 means the whole value was 59.99.
              if (sec10 == SEC10_MAX) begin
                sec10 <= '0;
                wrap  <= 1'b1;
              end else begin
                sec10 <= sec10 + BCD_W'(1);
              end
            end else begin
              sec1 <= sec1 + BCD_W'(1);
            end
          end else begin
            cs10 <= cs10 + BCD_W'(1);
          end
        end else begin
          cs1 <= cs1 + BCD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE sequencing, ms-to-cs prescaler, lap hold
// register and display mux over the BCD cascade.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_CS = 10
) (
  input  logic clk,
  input  logic reset_p,
  input  logic tick_msec,
  input  logic btn_start,
  input  logic btn_lap,
  input  logic btn_clear,
  output bcd_t disp_cs1,
  output bcd_t disp_cs10,
  output bcd_t disp_sec1,
  output bcd_t disp_sec10,
  output logic running,
  output logic lap_active,
  output logic wrap
);

  localparam int unsigned PRESC_W = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_CS - 1);

  sw_state_e state_q, state_d;
  logic clear_c;
  logic lap_toggle_c;
  logic count_en;
  logic cs_inc;
  logic [PRESC_W-1:0] presc_q;
  sw_time_t live;
  sw_time_t lap_q;
  sw_time_t shown;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= IDLE;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == RUN);
    end
  end

  // Button priority start > clear > lap; a lower pulse in the same cycle is dropped.
  always_comb begin
    state_d      = state_q;
    clear_c      = 1'b0;
    lap_toggle_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_start) state_d = RUN;
        else if (btn_clear) clear_c = 1'b1;
      end
      RUN: begin
        if (btn_start) state_d = PAUSE;
        else if (!btn_clear && btn_lap) lap_toggle_c = 1'b1;
      end
      PAUSE: begin
        if (btn_start) begin
          state_d = RUN;
        end else if (btn_clear) begin
          state_d = IDLE;
          clear_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tick is judged against the current state, so start+tick counts only in RUN.
  assign count_en = (state_q == RUN) && tick_msec;
  assign cs_inc   = count_en && (presc_q == PRESC_MAX);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      presc_q <= '0;
    end else if (clear_c) begin
      presc_q <= '0;
    end else if (count_en) begin
      presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_W'(1);
    end
  end

  bcd_cascade_ss_cc u_cascade (
    .clk     (clk),
    .reset_p (reset_p),
    .inc     (cs_inc),
    .clr     (clear_c),
    .cs1     (live.cs1),
    .cs10    (live.cs10),
    .sec1    (live.sec1),
    .sec10   (live.sec10),
    .wrap    (wrap)
  );

  // Lap captures the registered live value, i.e. before any same-edge increment.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      lap_q      <= '0;
      lap_active <= 1'b0;
    end else if (clear_c) begin
      lap_q      <= '0;
      lap_active <= 1'b0;
    end else if (lap_toggle_c) begin
      if (!lap_active) begin
        lap_q      <= live;
        lap_active <= 1'b1;
      end else begin
        lap_active <= 1'b0;
      end
    end
  end

  assign shown      = lap_active ? lap_q : live;
  assign disp_cs1   = shown.cs1;
  assign disp_cs10  = shown.cs10;
  assign disp_sec1  = shown.sec1;
  assign disp_sec10 = shown.sec10;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl: an integer centisecond model
// predicts every cycle's outputs, which are queued and checked after each edge.
module tb_stopwatch_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic clk = 1'b0;
  logic reset_p = 1'b0;
  logic tick_msec = 1'b0;
  logic btn_start = 1'b0;
  logic btn_lap = 1'b0;
  logic btn_clear = 1'b0;
  logic [3:0] disp_cs1, disp_cs10, disp_sec1, disp_sec10;
  logic running, lap_active, wrap;

  int total = 0;
  int bad = 0;

  int m_st = M_IDLE;
  int m_cs = 0;
  int m_presc = 0;
  bit m_lap = 1'b0;
  int m_lap_cs = 0;
  bit m_wrap = 1'b0;

  logic [18:0] exp_q[$];
  string tag_q[$];

  stopwatch_ctrl #(.TICKS_PER_CS(10)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .tick_msec  (tick_msec),
    .btn_start  (btn_start),
    .btn_lap    (btn_lap),
    .btn_clear  (btn_clear),
    .disp_cs1   (disp_cs1),
    .disp_cs10  (disp_cs10),
    .disp_sec1  (disp_sec1),
    .disp_sec10 (disp_sec10),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  always #4 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [18:0] model_out();
    int v;
    v = m_lap ? m_lap_cs : m_cs;
    return {to_bcd(v), (m_st == M_RUN), m_lap, m_wrap};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_cs = 0; m_presc = 0; m_lap = 1'b0; m_lap_cs = 0; m_wrap = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit lp, input bit cl, input bit tk);
    int old_cs;
    old_cs = m_cs;
    m_wrap = 1'b0;
    if (m_st == M_RUN && tk) begin
      if (m_presc == 9) begin
        m_presc = 0;
        if (m_cs == 5999) begin
          m_cs = 0;
          m_wrap = 1'b1;
        end else begin
          m_cs = m_cs + 1;
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end
    if (st) begin
      m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
    end else if (cl) begin
      if (m_st != M_RUN) begin
        m_st = M_IDLE; m_cs = 0; m_presc = 0; m_lap = 1'b0; m_lap_cs = 0;
      end
    end else if (lp && m_st == M_RUN) begin
      if (!m_lap) begin
        m_lap = 1'b1;
        m_lap_cs = old_cs;
      end else begin
        m_lap = 1'b0;
      end
    end
  endtask

  task automatic check_one();
    logic [18:0] exp_v;
    logic [18:0] got_v;
    string t;
    t = tag_q.pop_front();
    exp_v = exp_q.pop_front();
    got_v = {disp_sec10, disp_sec1, disp_cs10, disp_cs1, running, lap_active, wrap};
    total++;
    assert (got_v === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (disp,run,lap,wrap)", t, got_v, exp_v);
    end
  endtask

  task automatic step(input bit st, input bit lp, input bit cl, input bit tk, input string tag);
    @(negedge clk);
    btn_start = st; btn_lap = lp; btn_clear = cl; tick_msec = tk;
    model_step(st, lp, cl, tk);
    exp_q.push_back(model_out());
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_one();
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; tick_msec = 1'b0;
  endtask

  task automatic run_ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  // Tick until the model shows target centiseconds right after an increment.
  task automatic run_to(input int target, input string tag);
    int guard;
    guard = 0;
    while (!(m_cs == target && m_presc == 0) && guard < 70000) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, tag);
      guard++;
    end
    total++;
    assert (guard < 70000) else begin
      bad++;
      $error("FAIL %s_reach observed=timeout expected=%0d", tag, target);
    end
  endtask

  initial begin
    #2 reset_p = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_out());
    tag_q.push_back("reset_state");
    check_one();
    @(negedge clk);
    reset_p = 1'b0;

    step(1'b0, 1'b0, 1'b0, 1'b1, "idle_tick_ignored");
    step(1'b1, 1'b0, 1'b0, 1'b0, "start_run");
    run_ticks(10, "first_cs");
    run_ticks(990, "to_1s");

    run_to(350, "to_0350");
    step(1'b0, 1'b1, 1'b0, 1'b0, "lap_set");
    run_ticks(200, "lap_hold");
    step(1'b0, 1'b1, 1'b0, 1'b0, "lap_release");

    run_to(380, "to_0380");
    run_ticks(9, "pre_edge");
    step(1'b0, 1'b1, 1'b0, 1'b1, "lap_with_inc");
    step(1'b0, 1'b1, 1'b0, 1'b0, "lap_release2");

    step(1'b0, 1'b0, 1'b1, 1'b0, "clear_in_run");
    step(1'b0, 1'b1, 1'b1, 1'b0, "clear_lap_in_run");

    run_to(1234, "to_1234");
    step(1'b1, 1'b0, 1'b0, 1'b1, "pause_with_tick");
    run_ticks(50, "pause_hold");
    step(1'b0, 1'b1, 1'b0, 1'b0, "lap_in_pause");
    step(1'b1, 1'b0, 1'b0, 1'b1, "resume_tick_dropped");
    run_ticks(10, "resume_count");
    step(1'b1, 1'b0, 1'b0, 1'b0, "pause2");
    step(1'b1, 1'b0, 1'b1, 1'b0, "start_clear_pause");
    run_ticks(5, "after_start_clear");

    run_to(5999, "to_5999");
    run_ticks(12, "wrap");

    run_to(700, "to_0700");
    step(1'b0, 1'b1, 1'b0, 1'b0, "lap_0700");
    run_to(707, "to_0707");
    step(1'b1, 1'b0, 1'b0, 1'b0, "pause_0707");
    run_ticks(3, "pause_lap_held");
    step(1'b0, 1'b0, 1'b1, 1'b0, "clear_pause");
    step(1'b0, 1'b0, 1'b1, 1'b1, "clear_idle");

    step(1'b1, 1'b0, 1'b0, 1'b0, "restart");
    run_ticks(37, "restart_count");

    @(negedge clk);
    #1 reset_p = 1'b1;
    model_reset();
    exp_q.push_back(model_out());
    tag_q.push_back("async_reset");
    #1;
    check_one();
    @(negedge clk);
    reset_p = 1'b0;
    run_ticks(12, "post_reset_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
